// File: rtl/conv_frame_loader_if.sv
// Frame-loader bus: serial bit stream in, packed channel bitmaps and handshake out.
// The slave modport is the loader; master is the stream source / conv-core side.
interface conv_frame_loader_if #(
    parameter int IC       = 8,
    parameter int IMG_SIZE = 30
);
    localparam int N = IMG_SIZE * IMG_SIZE;

    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic         clear;
    logic [N-1:0] img_out [0:IC-1];
    logic         data_in_ready;
    logic         conv_done;
    logic [7:0]   frame_count;

    modport master (
        output bit_in, bit_valid, clear, conv_done,
        input  bit_ready, img_out, data_in_ready, frame_count
    );

    modport slave (
        input  bit_in, bit_valid, clear, conv_done,
        output bit_ready, img_out, data_in_ready, frame_count
    );
endinterface

// File: rtl/conv_frame_loader.sv
// Packs a channel-major, row-major serial bit stream into IC bitmaps and holds
// the frame for the conv core until it pulses completion.
//
//   state | meaning
//   LOAD  | accepting bits; img_out being written, data_in_ready low
//   HOLD  | frame complete and frozen; data_in_ready high until conv_done
module conv_frame_loader #(
    parameter int IC       = 8,
    parameter int IMG_SIZE = 30
) (
    input  logic              clk,
    input  logic              rst,
    conv_frame_loader_if.slave bus
);
    localparam int N  = IMG_SIZE * IMG_SIZE;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (IC > 1) ? $clog2(IC) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(N - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(IC - 1);

    typedef enum logic {LOAD, HOLD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          dir_q, dir_d;
    logic [7:0]    fc_q, fc_d;
    logic          wr_en;
    logic [N-1:0]  img_q [0:IC-1];

    assign bus.bit_ready     = !rst && (state_q == LOAD);
    assign bus.data_in_ready = dir_q;
    assign bus.frame_count   = fc_q;
    assign bus.img_out       = img_q;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        fc_d    = fc_q;
        wr_en   = 1'b0;
        // clear outranks both a transfer and a completion pulse
        if (bus.clear) begin
            state_d = LOAD;
            pix_d   = '0;
            ch_d    = '0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.bit_valid) begin
                        wr_en = 1'b1;
                        if (pix_q == PIX_LAST) begin
                            pix_d = '0;
                            if (ch_q == CH_LAST) begin
                                ch_d    = '0;
                                state_d = HOLD;
                                dir_d   = 1'b1;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.conv_done) begin
                        state_d = LOAD;
                        pix_d   = '0;
                        ch_d    = '0;
                        dir_d   = 1'b0;
                        fc_d    = fc_q + 8'd1;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            pix_q   <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            fc_q    <= '0;
            for (int c = 0; c < IC; c++) img_q[c] <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            fc_q    <= fc_d;
            if (wr_en) img_q[ch_q][pix_q] <= bus.bit_in;
        end
    end
endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader against a linear-index frame model.
module tb_conv_frame_loader;
    localparam int IC       = 2;
    localparam int IMG_SIZE = 4;
    localparam int N        = IMG_SIZE * IMG_SIZE;
    localparam int FB       = IC * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_frame_loader_if #(.IC(IC), .IMG_SIZE(IMG_SIZE)) intf ();
    conv_frame_loader #(.IC(IC), .IMG_SIZE(IMG_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: frame contents, bits taken so far in this frame, frame-ready flag, release count
    logic [N-1:0] exp_img [IC];
    int           exp_k;
    bit           exp_dir;
    logic [7:0]   exp_fc;

    task automatic tick();
        if (rst) begin
            for (int c = 0; c < IC; c++) exp_img[c] = '0;
            exp_k = 0; exp_dir = 0; exp_fc = 8'd0;
        end else if (intf.clear) begin
            exp_k = 0; exp_dir = 0;
        end else if (!exp_dir) begin
            if (intf.bit_valid) begin
                exp_img[exp_k / N][exp_k % N] = intf.bit_in;
                exp_k++;
                if (exp_k == FB) begin
                    exp_k = 0; exp_dir = 1;
                end
            end
        end else if (intf.conv_done) begin
            exp_dir = 0; exp_fc = exp_fc + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        intf.bit_in = 0; intf.bit_valid = 0; intf.clear = 0; intf.conv_done = 0;
    endtask

    task automatic drive_bits(input logic [FB-1:0] frame, input int from, input int to, input bit gapped);
        for (int k = from; k <= to; k++) begin
            if (gapped) begin
                intf.bit_valid = 0; intf.bit_in = 1'($urandom); tick();
            end
            intf.bit_valid = 1; intf.bit_in = frame[k]; tick();
        end
        intf.bit_valid = 0;
    endtask

    task automatic release_frame();
        intf.conv_done = 1; tick(); intf.conv_done = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        #1;
        n_vec++;
        if (intf.bit_ready !== 1'b0) begin n_err++; $display("FAIL reset bit_ready_in_rst: got %b expected 0", intf.bit_ready); end
        tick();
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL reset data_in_ready: got %b expected 0", intf.data_in_ready); end
        n_vec++;
        if (intf.frame_count !== 8'd0) begin n_err++; $display("FAIL reset frame_count: got %0d expected 0", intf.frame_count); end
        for (int c = 0; c < IC; c++) begin
            n_vec++;
            if (intf.img_out[c] !== 16'h0000) begin n_err++; $display("FAIL reset img ch%0d: got %h expected 0000", c, intf.img_out[c]); end
        end
        rst = 0;
        #1;
        n_vec++;
        if (intf.bit_ready !== 1'b1) begin n_err++; $display("FAIL reset bit_ready_after: got %b expected 1", intf.bit_ready); end
    endtask

    task automatic test_full_load();
        logic [FB-1:0] fr = {16'h0F0F, 16'hA5C3};
        drive_bits(fr, 0, FB - 2, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL full_load early_ready: got %b expected 0 after 31 bits", intf.data_in_ready); end
        drive_bits(fr, FB - 1, FB - 1, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b1) begin n_err++; $display("FAIL full_load ready: got %b expected 1 after 32 bits", intf.data_in_ready); end
        n_vec++;
        if (intf.img_out[0] !== 16'hA5C3) begin n_err++; $display("FAIL full_load img0: got %h expected a5c3", intf.img_out[0]); end
        n_vec++;
        if (intf.img_out[1] !== 16'h0F0F) begin n_err++; $display("FAIL full_load img1: got %h expected 0f0f", intf.img_out[1]); end
        n_vec++;
        if (intf.bit_ready !== 1'b0) begin n_err++; $display("FAIL full_load bit_ready: got %b expected 0", intf.bit_ready); end
    endtask

    task automatic test_hold_release();
        for (int i = 0; i < 10; i++) begin
            intf.bit_valid = 1; intf.bit_in = 1'($urandom);
            n_vec++;
            if (intf.bit_ready !== 1'b0) begin n_err++; $display("FAIL hold bit_ready cyc%0d: got %b expected 0", i, intf.bit_ready); end
            tick();
            n_vec++;
            if (intf.data_in_ready !== 1'b1) begin n_err++; $display("FAIL hold ready cyc%0d: got %b expected 1", i, intf.data_in_ready); end
        end
        intf.bit_valid = 0;
        for (int c = 0; c < IC; c++) begin
            n_vec++;
            if (intf.img_out[c] !== exp_img[c]) begin n_err++; $display("FAIL hold frozen img%0d: got %h expected %h", c, intf.img_out[c], exp_img[c]); end
        end
        release_frame();
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL release ready: got %b expected 0", intf.data_in_ready); end
        n_vec++;
        if (intf.frame_count !== 8'd1) begin n_err++; $display("FAIL release frame_count: got %0d expected 1", intf.frame_count); end
        n_vec++;
        if (intf.bit_ready !== 1'b1) begin n_err++; $display("FAIL release bit_ready: got %b expected 1", intf.bit_ready); end
    endtask

    task automatic test_gapped();
        logic [FB-1:0] fr = {16'h0F0F, 16'hA5C3};
        drive_bits(fr, 0, FB - 2, 1);
        intf.bit_valid = 0; intf.bit_in = 1'($urandom); tick();
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL gapped early_ready: got %b expected 0 at cycle 63", intf.data_in_ready); end
        intf.bit_valid = 1; intf.bit_in = fr[FB-1]; tick();
        intf.bit_valid = 0;
        n_vec++;
        if (intf.data_in_ready !== 1'b1) begin n_err++; $display("FAIL gapped ready: got %b expected 1 at cycle 64", intf.data_in_ready); end
        n_vec++;
        if (intf.img_out[0] !== 16'hA5C3) begin n_err++; $display("FAIL gapped img0: got %h expected a5c3", intf.img_out[0]); end
        n_vec++;
        if (intf.img_out[1] !== 16'h0F0F) begin n_err++; $display("FAIL gapped img1: got %h expected 0f0f", intf.img_out[1]); end
        release_frame();
    endtask

    task automatic test_clear_mid_frame();
        logic [FB-1:0] fr = {$urandom, $urandom};
        logic [FB-1:0] ones = '1;
        logic          victim;
        drive_bits(fr, 0, 19, 0);
        victim = exp_img[20 / N][20 % N];
        intf.clear = 1; intf.bit_valid = 1; intf.bit_in = ~victim;
        tick();
        idle();
        n_vec++;
        if (intf.img_out[20 / N][20 % N] !== victim) begin n_err++; $display("FAIL clear discarded_bit: got %b expected %b", intf.img_out[20 / N][20 % N], victim); end
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL clear ready: got %b expected 0", intf.data_in_ready); end
        drive_bits(ones, 0, FB - 2, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL clear early_ready: got %b expected 0 after 31 bits", intf.data_in_ready); end
        drive_bits(ones, FB - 1, FB - 1, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b1) begin n_err++; $display("FAIL clear ready_after_32: got %b expected 1", intf.data_in_ready); end
        for (int c = 0; c < IC; c++) begin
            n_vec++;
            if (intf.img_out[c] !== 16'hFFFF) begin n_err++; $display("FAIL clear img%0d: got %h expected ffff", c, intf.img_out[c]); end
        end
        release_frame();
    endtask

    task automatic test_done_edge_cases();
        logic [FB-1:0] fr = {$urandom, $urandom};
        logic [7:0]    fc0 = exp_fc;
        drive_bits(fr, 0, 4, 0);
        intf.conv_done = 1; intf.bit_valid = 1; intf.bit_in = fr[5];
        tick();
        idle();
        n_vec++;
        if (intf.frame_count !== fc0) begin n_err++; $display("FAIL done_in_load frame_count: got %0d expected %0d", intf.frame_count, fc0); end
        drive_bits(fr, 6, FB - 1, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b1) begin n_err++; $display("FAIL done_in_load ready: got %b expected 1", intf.data_in_ready); end
        n_vec++;
        if ({intf.img_out[1], intf.img_out[0]} !== fr) begin n_err++; $display("FAIL done_in_load img: got %h expected %h", {intf.img_out[1], intf.img_out[0]}, fr); end
        intf.clear = 1; intf.conv_done = 1;
        tick();
        idle();
        n_vec++;
        if (intf.frame_count !== fc0) begin n_err++; $display("FAIL clear_with_done frame_count: got %0d expected %0d", intf.frame_count, fc0); end
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL clear_with_done ready: got %b expected 0", intf.data_in_ready); end
        n_vec++;
        if (intf.bit_ready !== 1'b1) begin n_err++; $display("FAIL clear_with_done bit_ready: got %b expected 1", intf.bit_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            intf.bit_valid = ($urandom_range(0, 3) != 0);
            intf.bit_in    = 1'($urandom);
            intf.conv_done = exp_dir ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            intf.clear     = ($urandom_range(0, 99) == 0);
            n_vec++;
            if (intf.bit_ready !== !exp_dir) begin n_err++; $display("FAIL random bit_ready cyc%0d: got %b expected %b", i, intf.bit_ready, !exp_dir); end
            tick();
            n_vec++;
            if (intf.data_in_ready !== exp_dir) begin n_err++; $display("FAIL random ready cyc%0d: got %b expected %b", i, intf.data_in_ready, exp_dir); end
            n_vec++;
            if (intf.frame_count !== exp_fc) begin n_err++; $display("FAIL random frame_count cyc%0d: got %0d expected %0d", i, intf.frame_count, exp_fc); end
            for (int c = 0; c < IC; c++) begin
                n_vec++;
                if (intf.img_out[c] !== exp_img[c]) begin n_err++; $display("FAIL random img%0d cyc%0d: got %h expected %h", c, i, intf.img_out[c], exp_img[c]); end
            end
        end
        idle();
    endtask

    task automatic test_reset_and_wrap();
        logic [FB-1:0] fr = {$urandom, $urandom};
        drive_bits(fr, 0, 9, 0);
        rst = 1; tick(); rst = 0;
        n_vec++;
        if ({intf.img_out[1], intf.img_out[0]} !== '0) begin n_err++; $display("FAIL mid_reset img: got %h expected 0", {intf.img_out[1], intf.img_out[0]}); end
        n_vec++;
        if (intf.frame_count !== 8'd0) begin n_err++; $display("FAIL mid_reset frame_count: got %0d expected 0", intf.frame_count); end
        drive_bits(fr, 0, FB - 2, 0);
        n_vec++;
        if (intf.data_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset partial_lost: got %b expected 0 after 31 bits", intf.data_in_ready); end
        drive_bits(fr, FB - 1, FB - 1, 0);
        release_frame();
        for (int f = 1; f < 256; f++) begin
            fr = {$urandom, $urandom};
            drive_bits(fr, 0, FB - 1, 0);
            if (f == 255) begin
                n_vec++;
                if (intf.frame_count !== 8'd255) begin n_err++; $display("FAIL wrap frame_count_255: got %0d expected 255", intf.frame_count); end
            end
            release_frame();
        end
        n_vec++;
        if (intf.frame_count !== 8'd0) begin n_err++; $display("FAIL wrap frame_count_0: got %0d expected 0", intf.frame_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_full_load();
        test_hold_release();
        test_gapped();
        test_clear_mid_frame();
        test_done_edge_cases();
        test_random();
        test_reset_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
